mul_job_sequencer: RTL and testbench

- Upstream front-end for the 16-bit repeated-addition multiplier (datapath + controller pair).
- Accepts operand pairs on a valid/ready interface and serialises them onto the multiplier's start/in bus: multiplier first, multiplicand next cycle.
- Waits for done, captures the product and presents it downstream with valid/ready.
- Adds a zero-operand bypass, a done-timeout error and a job counter.

---
 rtl/mul_job_sequencer_if.sv | 43 ++++
 rtl/mul_job_sequencer.sv | 140 ++++++++++++++
 tb/tb_mul_job_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_job_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_job_sequencer_if
// Bundles the three buses of the job sequencer:
//   upstream   : in_valid / in_ready / in_a / in_b          (operand pair)
//   multiplier : mul_start / mul_data / mul_done / mul_product
//   downstream : out_valid / out_ready / out_product / out_err
// Handshake rule for both valid/ready pairs: a transfer happens on a rising
// clk edge where valid && ready; valid, once raised, holds its payload stable
// until that edge.
// Modports:
//   slave  - the sequencer side (accepts operands, drives the multiplier bus,
//            offers results)
//   master - the surrounding system (offers operands, models the multiplier,
//            consumes results)
// -----------------------------------------------------------------------------
interface mul_job_sequencer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic         mul_start;
    logic [W-1:0] mul_data;
    logic         mul_done;
    logic [W-1:0] mul_product;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_product;
    logic         out_err;

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_product, out_ready,
        output in_ready, mul_start, mul_data, out_valid, out_product, out_err
    );

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_product, out_ready,
        input  in_ready, mul_start, mul_data, out_valid, out_product, out_err
    );
endinterface

// File: rtl/mul_job_sequencer.sv
// -----------------------------------------------------------------------------
// mul_job_sequencer
// Front-end for the 16-bit repeated-addition multiplier. Takes an operand pair,
// puts the multiplier on mul_data for one start cycle and the multiplicand on
// the following cycles, waits for mul_done (bounded by TIMEOUT), and offers
// the product downstream. A zero operand skips the multiplier entirely.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-low
//   bus         - mul_job_sequencer_if.slave (upstream, multiplier, downstream)
//   busy        - high whenever the sequencer is not idle
//   job_count   - number of completed output handshakes, wraps at 2^16
//   o_dbg_state - current FSM state (IDLE=0, SEND_A=1, SEND_B=2, WAIT=3,
//                 RESULT=4)
// -----------------------------------------------------------------------------
module mul_job_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 65600,
    parameter int CW      = 17
) (
    input  logic                clk,
    input  logic                reset,
    mul_job_sequencer_if.slave  bus,
    output logic                busy,
    output logic [15:0]         job_count,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_A = 3'd1,
        S_SEND_B = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_mul_data;
    logic [W-1:0]  r_out_product;
    logic          r_mul_start;
    logic          r_out_valid;
    logic          r_out_err;
    logic          r_busy;
    logic [15:0]   r_job_count;
    logic [CW-1:0] r_cnt;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_zero;

    assign w_in_ready = (r_state == S_IDLE);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_zero     = (bus.in_a == '0) || (bus.in_b == '0);

    // The multiplier operand goes straight into r_mul_data at accept, so it
    // needs no separate holding register; only the multiplicand is kept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_b           <= '0;
            r_mul_data    <= '0;
            r_out_product <= '0;
            r_mul_start   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_job_count   <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_b    <= bus.in_b;
                        r_busy <= 1'b1;
                        if (w_zero) begin
                            // Product is known to be zero: skip the multiplier.
                            r_state       <= S_RESULT;
                            r_out_valid   <= 1'b1;
                            r_out_product <= '0;
                            r_out_err     <= 1'b0;
                        end else begin
                            r_state     <= S_SEND_A;
                            r_mul_start <= 1'b1;
                            r_mul_data  <= bus.in_a;
                        end
                    end
                end
                S_SEND_A: begin
                    r_mul_data <= r_b;
                    r_state    <= S_SEND_B;
                end
                S_SEND_B: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // done is checked first so a done on the final allowed
                    // cycle still yields a good product.
                    if (bus.mul_done) begin
                        r_out_product <= bus.mul_product;
                        r_out_err     <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_mul_start   <= 1'b0;
                        r_state       <= S_RESULT;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_out_product <= '0;
                        r_out_err     <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_mul_start   <= 1'b0;
                        r_state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_job_count <= r_job_count + 16'd1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.mul_start   = r_mul_start;
    assign bus.mul_data    = r_mul_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_product = r_out_product;
    assign bus.out_err     = r_out_err;
    assign busy            = r_busy;
    assign job_count       = r_job_count;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mul_job_sequencer.sv
module tb_mul_job_sequencer;

    localparam int W    = 16;
    localparam int TOUT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [15:0] job_count;
    logic [2:0]  dbg_state;

    mul_job_sequencer_if #(.W(W)) bus ();

    mul_job_sequencer #(.W(W), .TIMEOUT(TOUT), .CW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .job_count   (job_count),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_jobs = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mul_start must stay low for >=2 sampled cycles between jobs
    bit prev_start = 1'b0;
    bit had_job    = 1'b0;
    int low_run    = 0;
    always @(negedge clk) begin
        if (bus.mul_start && !prev_start) begin
            if (had_job) check("start_gap", (low_run >= 2) ? 32'd1 : 32'd0, 32'd1);
            had_job = 1'b1;
            low_run = 0;
        end else if (!bus.mul_start) begin
            low_run++;
        end
        prev_start = bus.mul_start;
    end

    // driver: one job from offer to result handshake. lat is the WAIT cycle
    // (1-based) in which the multiplier model raises done; hold is how many
    // cycles the result is back-pressured; stale raises a bogus done while the
    // operands are being sent.
    task automatic do_job(input logic [15:0] a, input logic [15:0] b,
                          input int lat, input int hold, input bit stale);
        bit          byp;
        bit          seen;
        int          exp_n;
        int          n;
        logic        exp_err;
        logic [31:0] full;
        logic [15:0] exp_p;
        full = {16'd0, a} * {16'd0, b};
        byp  = (a == 16'd0) || (b == 16'd0);
        if (byp) begin
            exp_q.push_back('0); exp_err = 1'b0; exp_n = 0;
        end else if (lat <= TOUT) begin
            exp_q.push_back(full[15:0]); exp_err = 1'b0; exp_n = lat + 2;
        end else begin
            exp_q.push_back('0); exp_err = 1'b1; exp_n = TOUT + 2;
        end

        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);

        seen = 1'b0;
        n = 0;
        while (!seen && n <= TOUT + 8) begin
            if (bus.out_valid) begin
                seen = 1'b1;
            end else begin
                if (byp) begin
                    check("byp_no_start", bus.mul_start, 0);
                end else if (n == 0) begin
                    check("send_a_start", bus.mul_start, 1);
                    check("send_a_data", bus.mul_data, a);
                end else if (n == 1) begin
                    check("send_b_start", bus.mul_start, 1);
                    check("send_b_data", bus.mul_data, b);
                end
                bus.mul_done    = !byp && ((stale && n < 2) || (n - 1 == lat));
                bus.mul_product = (n - 1 == lat) ? full[15:0] : 16'($urandom);
                @(negedge clk);
                n++;
            end
        end
        bus.mul_done = 1'b0;

        check("result_seen", seen, 1);
        check("latency", n, exp_n);
        exp_p = exp_q.pop_front();
        if (seen) begin
            check("out_product", bus.out_product, exp_p);
            check("out_err", bus.out_err, exp_err);
            check("in_ready_busy", bus.in_ready, 0);
            check("busy_result", busy, 1);
            check("start_low_result", bus.mul_start, 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", bus.out_valid, 1);
                check("hold_product", bus.out_product, exp_p);
                check("hold_err", bus.out_err, exp_err);
                check("hold_in_ready", bus.in_ready, 0);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            exp_jobs++;
            check("valid_dropped", bus.out_valid, 0);
            check("job_count", job_count, exp_jobs[15:0]);
            check("in_ready_back", bus.in_ready, 1);
            check("busy_idle", busy, 0);
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        bus.out_ready   = 1'b0;

        // reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_mul_start", bus.mul_start, 0);
        check("rst_mul_data", bus.mul_data, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_product", bus.out_product, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_job_count", job_count, 0);
        reset = 1'b1;

        // directed cases
        do_job(16'd5, 16'd7, 7, 0, 1'b0);    // basic product 35
        do_job(16'd0, 16'd9, 3, 0, 1'b0);    // zero bypass
        do_job(16'd10, 16'd20, 5, 4, 1'b0);  // product 200, back-pressure 4 cycles
        do_job(16'd3, 16'd4, 25, 0, 1'b0);   // timeout
        do_job(16'd3, 16'd4, TOUT, 0, 1'b0); // done on the last allowed cycle wins
        do_job(16'd6, 16'd0, 2, 1, 1'b0);    // zero in the multiplicand
        do_job(16'd9, 16'd11, 1, 0, 1'b1);   // stale done ignored, done in WAIT 1

        // reset during WAIT
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = 16'd9; bus.in_b = 16'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_jobs = 0;
        check("mid_rst_start", bus.mul_start, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_job_count", job_count, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_result", bus.out_valid, 0);

        // back-to-back random jobs, operands 1..256
        for (int j = 0; j < 10; j++) begin
            do_job(16'($urandom_range(256, 1)), 16'($urandom_range(256, 1)),
                   $urandom_range(TOUT, 1), $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end
        check("job_count_10", job_count, 10);

        // wider random mix: zeros, full-range operands, timeouts
        for (int j = 0; j < 8; j++) begin
            do_job(($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom),
                   16'($urandom),
                   $urandom_range(TOUT + 4, 1), $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
